// File: rtl/fft_sdf_stage_8.sv
// Radix-2 single-path delay-feedback butterfly stage with a DELAY-deep complex feedback line.
// Each accepted sample is filled, butterflied against the line head, or twiddled, with a one-cycle registered output.
module fft_sdf_stage_8 #(
    parameter int unsigned DW    = 24,
    parameter int unsigned DELAY = 8,
    parameter int unsigned FRAC  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] din_r,
    input  logic [DW-1:0] din_i,
    input  logic [1:0]    state,
    input  logic [DW-1:0] w_r,
    input  logic [DW-1:0] w_i,
    output logic          out_valid,
    output logic [DW-1:0] dout_r,
    output logic [DW-1:0] dout_i,
    output logic          err
);

    localparam int unsigned PW = 2 * DW + 1;

    localparam logic [1:0] PH_BFLY  = 2'd1;
    localparam logic [1:0] PH_TWID  = 2'd2;
    localparam logic [1:0] PH_ILLEG = 2'd3;

    logic [DW-1:0] dl_r_q [DELAY];
    logic [DW-1:0] dl_i_q [DELAY];
    logic [DW-1:0] dl_r_d [DELAY];
    logic [DW-1:0] dl_i_d [DELAY];

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] dout_r_q, dout_r_d;
    logic [DW-1:0] dout_i_q, dout_i_d;
    logic          err_q, err_d;

    logic          advance;
    logic [DW-1:0] push_r, push_i;
    logic signed [PW-1:0] ar_x, ai_x, wr_x, wi_x;
    logic signed [PW-1:0] pr_full, pi_full;

    // Full-precision complex product of the line head and the twiddle
    always_comb begin
        ar_x    = PW'($signed(dl_r_q[0]));
        ai_x    = PW'($signed(dl_i_q[0]));
        wr_x    = PW'($signed(w_r));
        wi_x    = PW'($signed(w_i));
        pr_full = ar_x * wr_x - ai_x * wi_x;
        pi_full = ar_x * wi_x + ai_x * wr_x;
    end

    // Phase decode, output selection and delay-line shift
    always_comb begin
        dl_r_d      = dl_r_q;
        dl_i_d      = dl_i_q;
        out_valid_d = 1'b0;
        dout_r_d    = dout_r_q;
        dout_i_d    = dout_i_q;
        err_d       = err_q;
        push_r      = din_r;
        push_i      = din_i;
        advance     = in_valid && (state != PH_ILLEG);

        if (in_valid && (state == PH_ILLEG)) begin
            err_d = 1'b1;
        end

        if (advance) begin
            case (state)
                PH_BFLY: begin
                    out_valid_d = 1'b1;
                    dout_r_d    = dl_r_q[0] + din_r;
                    dout_i_d    = dl_i_q[0] + din_i;
                    push_r      = dl_r_q[0] - din_r;
                    push_i      = dl_i_q[0] - din_i;
                end
                PH_TWID: begin
                    out_valid_d = 1'b1;
                    dout_r_d    = DW'(pr_full >>> FRAC);
                    dout_i_d    = DW'(pi_full >>> FRAC);
                end
                default: ;
            endcase

            for (int i = 0; i < int'(DELAY) - 1; i++) begin
                dl_r_d[i] = dl_r_q[i+1];
                dl_i_d[i] = dl_i_q[i+1];
            end
            dl_r_d[DELAY-1] = push_r;
            dl_i_d[DELAY-1] = push_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DELAY); i++) begin
                dl_r_q[i] <= '0;
                dl_i_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            dout_r_q    <= '0;
            dout_i_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            dl_r_q      <= dl_r_d;
            dl_i_q      <= dl_i_d;
            out_valid_q <= out_valid_d;
            dout_r_q    <= dout_r_d;
            dout_i_q    <= dout_i_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dout_r    = dout_r_q;
    assign dout_i    = dout_i_q;
    assign err       = err_q;

endmodule

// File: tb/tb_fft_sdf_stage_8.sv
// Directed bench for fft_sdf_stage_8: a queue-based delay-line model feeds a scoreboard of expected outputs.
module tb_fft_sdf_stage_8;

    localparam int unsigned DW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] din_r = '0, din_i = '0, w_r = '0, w_i = '0;
    logic [1:0]    state = 2'd0;
    logic          out_valid, err;
    logic [DW-1:0] dout_r, dout_i;

    fft_sdf_stage_8 #(.DW(24), .DELAY(8), .FRAC(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .din_r(din_r), .din_i(din_i), .state(state),
        .w_r(w_r), .w_i(w_i),
        .out_valid(out_valid), .dout_r(dout_r), .dout_i(dout_i), .err(err)
    );

    always #5 clk = ~clk;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    logic signed [DW-1:0] mq_r[$], mq_i[$];
    logic [DW-1:0]        sb_r[$], sb_i[$];
    logic                 exp_v   = 1'b0;
    logic                 exp_err = 1'b0;
    logic [DW-1:0]        last_r  = '0, last_i = '0;

    // exp(-j*2*pi*k/16) in Q8
    int wt_r[8] = '{256, 237, 181, 98, 0, -98, -181, -237};
    int wt_i[8] = '{0, -98, -181, -237, -256, -237, -181, -98};

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        mq_r.delete(); mq_i.delete(); sb_r.delete(); sb_i.delete();
        for (int i = 0; i < 8; i++) begin
            mq_r.push_back('0); mq_i.push_back('0);
        end
        exp_err = 1'b0; last_r = '0; last_i = '0; exp_v = 1'b0;
    endtask

    // Drive one cycle, advance the model, then check the registered response
    task automatic step(input logic v, input logic [1:0] st, input logic [DW-1:0] dr, input logic [DW-1:0] di,
                        input logic [DW-1:0] wr, input logic [DW-1:0] wi);
        logic signed [DW-1:0] a_r, a_i;
        longint pr, pim;
        in_valid = v; state = st; din_r = dr; din_i = di; w_r = wr; w_i = wi;
        exp_v = 1'b0;
        if (v) begin
            if (st == 2'd3) begin
                exp_err = 1'b1;
            end else begin
                a_r = mq_r.pop_front();
                a_i = mq_i.pop_front();
                if (st == 2'd1) begin
                    sb_r.push_back(DW'(a_r + dr));
                    sb_i.push_back(DW'(a_i + di));
                    mq_r.push_back(DW'(a_r - dr));
                    mq_i.push_back(DW'(a_i - di));
                    exp_v = 1'b1;
                end else begin
                    mq_r.push_back(dr);
                    mq_i.push_back(di);
                    if (st == 2'd2) begin
                        pr  = longint'(a_r) * longint'($signed(wr)) - longint'(a_i) * longint'($signed(wi));
                        pim = longint'(a_r) * longint'($signed(wi)) + longint'(a_i) * longint'($signed(wr));
                        pr  = pr >>> 8;
                        pim = pim >>> 8;
                        sb_r.push_back(DW'(pr));
                        sb_i.push_back(DW'(pim));
                        exp_v = 1'b1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", DW'(out_valid), DW'(exp_v));
        chk("err", DW'(err), DW'(exp_err));
        if (exp_v && sb_r.size() > 0) begin
            last_r = sb_r.pop_front();
            last_i = sb_i.pop_front();
        end
        chk("dout_r", dout_r, last_r);
        chk("dout_i", dout_i, last_i);
    endtask

    task automatic idle();
        step(1'b0, 2'($urandom_range(0, 3)), DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
    endtask

    // Reference frame: fill k*256, butterfly 256, twiddle with din=0; optional random gaps
    task automatic frame_a(input bit gaps);
        for (int k = 0; k < 8; k++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) idle();
            step(1'b1, 2'd0, DW'(k * 256), '0, '0, '0);
        end
        for (int k = 0; k < 8; k++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) idle();
            step(1'b1, 2'd1, DW'(256), '0, '0, '0);
        end
        for (int k = 0; k < 8; k++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) idle();
            step(1'b1, 2'd2, '0, '0, DW'(wt_r[k]), DW'(wt_i[k]));
        end
    endtask

    initial begin
        model_clear();
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_dout_r", dout_r, '0);
        chk("rst_dout_i", dout_i, '0);
        chk("rst_err", DW'(err), '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        frame_a(1'b0);
        // Hand-derived frame outputs: last twiddle k=0 -> (-256,0) and k=4 -> (0,-768) were already scored;
        // re-run with gaps and the model must agree again
        frame_a(1'b1);

        // Truncation toward -inf
        step(1'b1, 2'd0, DW'(1), '0, '0, '0);
        step(1'b1, 2'd0, DW'(-1), '0, '0, '0);
        for (int k = 2; k < 8; k++) step(1'b1, 2'd0, DW'($urandom), DW'($urandom), '0, '0);
        step(1'b1, 2'd2, '0, '0, DW'(237), DW'(-98));
        chk("trunc_pos_r", last_r, DW'(0));
        chk("trunc_pos_i", last_i, DW'(-1));
        step(1'b1, 2'd2, '0, '0, DW'(237), DW'(-98));
        chk("trunc_neg_r", last_r, DW'(-1));
        chk("trunc_neg_i", last_i, DW'(0));
        for (int k = 2; k < 8; k++) step(1'b1, 2'd2, '0, '0, DW'($urandom_range(0, 511) - 256), DW'($urandom_range(0, 511) - 256));

        // Wraparound on butterfly sum and stored difference
        step(1'b1, 2'd0, DW'(24'h7FFFFF), '0, '0, '0);
        for (int k = 1; k < 8; k++) step(1'b1, 2'd0, DW'($urandom), DW'($urandom), '0, '0);
        step(1'b1, 2'd1, DW'(1), '0, '0, '0);
        chk("wrap_sum", last_r, DW'(24'h800000));
        for (int k = 1; k < 8; k++) step(1'b1, 2'd1, DW'($urandom), DW'($urandom), '0, '0);
        step(1'b1, 2'd2, '0, '0, DW'(256), '0);
        chk("wrap_diff", last_r, DW'(24'h7FFFFE));
        for (int k = 1; k < 8; k++) step(1'b1, 2'd2, '0, '0, DW'(256), '0);

        // Illegal phase in the middle of a butterfly run
        for (int k = 0; k < 8; k++) step(1'b1, 2'd0, DW'(k * 100), DW'(k * 7), '0, '0);
        for (int k = 0; k < 4; k++) step(1'b1, 2'd1, DW'(3), DW'(1), '0, '0);
        step(1'b1, 2'd3, DW'($urandom), DW'($urandom), '0, '0);
        chk("illegal_err", DW'(err), DW'(1));
        step(1'b1, 2'd1, DW'(3), DW'(1), '0, '0);
        chk("after_illegal_r", last_r, DW'(403));
        for (int k = 5; k < 8; k++) step(1'b1, 2'd1, DW'(3), DW'(1), '0, '0);
        for (int k = 0; k < 4; k++) step(1'b1, 2'd2, '0, '0, DW'(wt_r[k]), DW'(wt_i[k]));

        // Asynchronous reset during the twiddle phase
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", DW'(out_valid), '0);
        chk("midrst_dout_r", dout_r, '0);
        chk("midrst_dout_i", dout_i, '0);
        chk("midrst_err", DW'(err), '0);
        model_clear();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 8; k++) step(1'b1, 2'd0, '0, '0, '0, '0);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 2'd1, DW'(5), '0, '0, '0);
            chk("post_rst_bfly", dout_r, DW'(5));
        end
        idle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
